// File: rtl/keypad_digit_source.sv
// keypad_digit_source
//
// Scans a 4x4 active-low matrix keypad, debounces presses and releases, and maps
// keys 0-9 to a 4-bit digit with an enable. Key 'A' clears the enable. Every other
// key runs through the same press/release sequence but has no effect. A new
// selection is kept as pending and is only copied to the display outputs on a
// frame-start pulse, so the shown digit never changes in the middle of a frame.
//
// Parameters:
//   SCAN_DIV     cycles each column is driven before its rows are sampled (>= 4)
//   DEB_CYCLES   consecutive stable cycles needed to accept a press or a release
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_rows         keypad rows, active-low, asynchronous to i_clk
//   i_frame_start  one-cycle pulse at the start of vertical blanking
//   o_cols         column drive, exactly one bit low
//   o_digit        committed digit 0-9
//   o_digit_en     1 = show digit, 0 = show instruction text
//   o_key_strobe   one-cycle pulse when a mapped key is accepted

module keypad_digit_source #(
    parameter logic [15:0] SCAN_DIV   = 16'd1000,
    parameter logic [19:0] DEB_CYCLES = 20'd100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_rows,
    input  logic       i_frame_start,
    output logic [3:0] o_cols,
    output logic [3:0] o_digit,
    output logic       o_digit_en,
    output logic       o_key_strobe
);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e      r_state;
    logic [3:0]  r_rows_meta;
    logic [3:0]  r_rows_s;
    logic [1:0]  r_col;
    logic [1:0]  r_row;
    logic [15:0] r_scan_cnt;
    logic [19:0] r_deb_cnt;
    logic [3:0]  r_pend_digit;
    logic        r_pend_en;
    logic [3:0]  r_cols;
    logic [3:0]  r_digit;
    logic        r_digit_en;
    logic        r_key_strobe;

    logic        w_any_low;
    logic [1:0]  w_low_row;
    logic        w_tracked_high;
    logic [3:0]  w_key_idx;
    logic        w_map_valid;
    logic [3:0]  w_map_digit;
    logic        w_map_en;

    assign w_any_low      = ~&r_rows_s;
    assign w_tracked_high = r_rows_s[r_row];
    assign w_key_idx      = {r_row, r_col};

    // Lowest-index low row wins when several rows are pressed in one column.
    always_comb begin
        w_low_row = 2'd3;
        if (!r_rows_s[0]) begin
            w_low_row = 2'd0;
        end else if (!r_rows_s[1]) begin
            w_low_row = 2'd1;
        end else if (!r_rows_s[2]) begin
            w_low_row = 2'd2;
        end
    end

    // Key map indexed by {row, col}; unmapped keys leave pending untouched.
    always_comb begin
        w_map_valid = 1'b1;
        w_map_digit = 4'd0;
        w_map_en    = 1'b1;
        case (w_key_idx)
            4'd0:    w_map_digit = 4'd1;
            4'd1:    w_map_digit = 4'd2;
            4'd2:    w_map_digit = 4'd3;
            4'd3:    w_map_en    = 1'b0;   // 'A' clears the display
            4'd4:    w_map_digit = 4'd4;
            4'd5:    w_map_digit = 4'd5;
            4'd6:    w_map_digit = 4'd6;
            4'd8:    w_map_digit = 4'd7;
            4'd9:    w_map_digit = 4'd8;
            4'd10:   w_map_digit = 4'd9;
            4'd13:   w_map_digit = 4'd0;
            default: w_map_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StScan;
            r_rows_meta  <= 4'hF;
            r_rows_s     <= 4'hF;
            r_col        <= 2'd0;
            r_row        <= 2'd0;
            r_scan_cnt   <= 16'd0;
            r_deb_cnt    <= 20'd0;
            r_pend_digit <= 4'd0;
            r_pend_en    <= 1'b0;
            r_cols       <= 4'b1110;
            r_digit      <= 4'd0;
            r_digit_en   <= 1'b0;
            r_key_strobe <= 1'b0;
        end else begin
            r_rows_meta  <= i_rows;
            r_rows_s     <= r_rows_meta;
            // Column drive trails r_col by one cycle.
            r_cols       <= ~(4'b0001 << r_col);
            r_key_strobe <= 1'b0;

            // Uses the pending value from before this edge, so an accept on the
            // same cycle lands on the following frame.
            if (i_frame_start) begin
                r_digit    <= r_pend_digit;
                r_digit_en <= r_pend_en;
            end

            case (r_state)
                StScan: begin
                    if (r_scan_cnt == SCAN_DIV - 16'd1) begin
                        r_scan_cnt <= 16'd0;
                        if (w_any_low) begin
                            r_row     <= w_low_row;
                            r_deb_cnt <= 20'd0;
                            r_state   <= StDebounce;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 16'd1;
                    end
                end
                StDebounce: begin
                    if (w_tracked_high) begin
                        // Bounce: rescan the same column from the start.
                        r_scan_cnt <= 16'd0;
                        r_state    <= StScan;
                    end else if (r_deb_cnt == DEB_CYCLES - 20'd1) begin
                        if (w_map_valid) begin
                            r_pend_digit <= w_map_digit;
                            r_pend_en    <= w_map_en;
                            r_key_strobe <= 1'b1;
                        end
                        r_state <= StHeld;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 20'd1;
                    end
                end
                StHeld: begin
                    if (w_tracked_high) begin
                        r_deb_cnt <= 20'd0;
                        r_state   <= StRelease;
                    end
                end
                StRelease: begin
                    if (!w_tracked_high) begin
                        r_state <= StHeld;
                    end else if (r_deb_cnt == DEB_CYCLES - 20'd1) begin
                        r_col      <= r_col + 2'd1;
                        r_scan_cnt <= 16'd0;
                        r_state    <= StScan;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 20'd1;
                    end
                end
                default: r_state <= StScan;
            endcase
        end
    end

    assign o_cols       = r_cols;
    assign o_digit      = r_digit;
    assign o_digit_en   = r_digit_en;
    assign o_key_strobe = r_key_strobe;

endmodule

// File: tb/tb_keypad_digit_source.sv
// Directed bench for keypad_digit_source with SCAN_DIV=4, DEB_CYCLES=8.
// A keypad model pulls row key_r low whenever column key_c is driven and key_down is set.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_keypad_digit_source;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] digit;
    logic       digit_en;
    logic       key_strobe;

    logic       key_down;
    logic [1:0] key_r;
    logic [1:0] key_c;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          s;
    logic [31:0] sv;

    always #5 clk = ~clk;

    assign rows = (key_down && (cols[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

    keypad_digit_source #(
        .SCAN_DIV   (16'd4),
        .DEB_CYCLES (20'd8)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_rows        (rows),
        .i_frame_start (frame_start),
        .o_cols        (cols),
        .o_digit       (digit),
        .o_digit_en    (digit_en),
        .o_key_strobe  (key_strobe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_key(input logic [1:0] r, input logic [1:0] c, output int strobes);
        strobes  = 0;
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (key_strobe) strobes++;
        end
        key_down = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (key_strobe) strobes++;
        end
    endtask

    // Returns at the first falling edge where cols equals target.
    task automatic wait_cols(input string tag, input logic [3:0] target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (cols == target) ok = 1'b1;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        key_down    = 1'b0;
        key_r       = 2'd0;
        key_c       = 2'd0;

        // Reset values and column rotation.
        repeat (3) @(negedge clk);
        chk("rst_cols",   {28'd0, cols}, 32'hE);
        chk("rst_digit",  {28'd0, digit}, 32'h0);
        chk("rst_en",     {31'd0, digit_en}, 32'h0);
        chk("rst_strobe", {31'd0, key_strobe}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3)  chk("rot_k3",  {28'd0, cols}, 32'hE);
            if (k == 4)  chk("rot_k4",  {28'd0, cols}, 32'hD);
            if (k == 8)  chk("rot_k8",  {28'd0, cols}, 32'hB);
            if (k == 12) chk("rot_k12", {28'd0, cols}, 32'h7);
            if (k == 16) chk("rot_k16", {28'd0, cols}, 32'hE);
        end

        // Press '7' held from reset: detect at edge 3, accept at edge 11.
        key_r = 2'd2;
        key_c = 2'd0;
        key_down = 1'b1;
        do_reset();
        sv = '0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            sv[k] = key_strobe;
        end
        chk("p7_strobe_timing", sv, 32'h800);
        chk("p7_digit_before_frame", {28'd0, digit}, 32'h0);
        chk("p7_en_before_frame", {31'd0, digit_en}, 32'h0);
        frame();
        chk("p7_digit", {28'd0, digit}, 32'h7);
        chk("p7_en", {31'd0, digit_en}, 32'h1);
        key_down = 1'b0;
        repeat (40) @(negedge clk);

        // 'A' clears.
        run_key(2'd0, 2'd3, s);
        chk("a_strobes", s, 32'd1);
        chk("a_digit_held", {28'd0, digit}, 32'h7);
        frame();
        chk("a_digit", {28'd0, digit}, 32'h0);
        chk("a_en", {31'd0, digit_en}, 32'h0);

        // '3' then '#': '#' is ignored.
        run_key(2'd0, 2'd2, s);
        chk("k3_strobes", s, 32'd1);
        frame();
        chk("k3_digit", {28'd0, digit}, 32'h3);
        chk("k3_en", {31'd0, digit_en}, 32'h1);
        run_key(2'd3, 2'd2, s);
        chk("hash_strobes", s, 32'd0);
        frame();
        chk("hash_digit", {28'd0, digit}, 32'h3);
        chk("hash_en", {31'd0, digit_en}, 32'h1);

        // Bounce on '7' after reset: no accept, rescan stays on column 0.
        key_r = 2'd2;
        key_c = 2'd0;
        key_down = 1'b1;
        do_reset();
        sv = '0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            sv[k] = key_strobe;
            if (k == 5)  key_down = 1'b0;
            if (k == 7)  key_down = 1'b1;
            if (k == 12) key_down = 1'b0;
            if (k == 19) chk("bnc_cols_k19", {28'd0, cols}, 32'hE);
            if (k == 20) chk("bnc_cols_k20", {28'd0, cols}, 32'hD);
        end
        chk("bnc_strobes", sv, 32'h0);
        frame();
        chk("bnc_digit", {28'd0, digit}, 32'h0);
        chk("bnc_en", {31'd0, digit_en}, 32'h0);

        // Collision: pending=2, '5' accepted on the same edge as frameStart.
        run_key(2'd0, 2'd1, s);
        chk("k2_strobes", s, 32'd1);
        chk("k2_digit_held", {28'd0, digit}, 32'h0);
        wait_cols("col_wait_c0", 4'hE);
        key_r = 2'd1;
        key_c = 2'd1;
        key_down = 1'b1;
        wait_cols("col_wait_c1", 4'hD);
        repeat (10) @(negedge clk);
        frame();
        chk("col_strobe_aligned", {31'd0, key_strobe}, 32'h1);
        chk("col_digit_old", {28'd0, digit}, 32'h2);
        chk("col_en_old", {31'd0, digit_en}, 32'h1);
        frame();
        chk("col_digit_new", {28'd0, digit}, 32'h5);
        key_down = 1'b0;
        repeat (40) @(negedge clk);

        // Reset during debounce of '9' with the key still held.
        wait_cols("mid_wait_c1", 4'hD);
        key_r = 2'd2;
        key_c = 2'd2;
        key_down = 1'b1;
        wait_cols("mid_wait_c2", 4'hB);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cols", {28'd0, cols}, 32'hE);
        chk("mid_rst_digit", {28'd0, digit}, 32'h0);
        chk("mid_rst_en", {31'd0, digit_en}, 32'h0);
        chk("mid_rst_strobe", {31'd0, key_strobe}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sv = '0;
        s  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (key_strobe) begin
                s++;
                if (k < 32) sv[k] = 1'b1;
            end
        end
        chk("mid_strobe_count", s, 32'd1);
        chk("mid_strobe_timing", sv, 32'h0008_0000);
        key_down = 1'b0;
        repeat (30) @(negedge clk);
        frame();
        chk("mid_digit", {28'd0, digit}, 32'h9);
        chk("mid_en", {31'd0, digit_en}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
